// File: rtl/pcie_rx_reorder_pkg.sv
// Shared constants and types for the PCIe receive reorder buffer.
// Block geometry is fixed at 64 words of 64 bits (512 bytes) per tag.
package pcie_rx_reorder_pkg;
    localparam int WORDS_PER_TAG = 64;
    localparam int WORD_W        = 64;
    localparam int CNT_W         = 7;
    localparam int IDX_W         = 6;
    localparam int FIFO_DEPTH    = 2;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WORDS_PER_TAG);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORDS_PER_TAG - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    typedef enum logic [0:0] {
        RD_IDLE   = 1'b0,
        RD_STREAM = 1'b1
    } rd_state_e;
endpackage

// File: rtl/pcie_rx_reorder_ram.sv
// Simple dual-port block buffer: one write port, one read port with a
// one-cycle registered read. Contents are never reset.
module pcie_rx_reorder_ram
    import pcie_rx_reorder_pkg::*;
#(
    parameter int ADDR_W = 11
) (
    input  logic              clock,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WORD_W-1:0] rd_data
);
    logic [WORD_W-1:0] mem [2**ADDR_W];
    logic [WORD_W-1:0] rd_data_q;

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_q;
endmodule

// File: rtl/pcie_rx_reorder.sv
// Completion reorder buffer: stores completion words per tag, streams whole
// blocks out in tag-issue order and recycles tags once their block is read.
module pcie_rx_reorder
    import pcie_rx_reorder_pkg::*;
#(
    parameter int TAG_BITS = 5
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                completion_valid,
    input  logic [7:0]          completion_tag,
    input  logic [5:0]          completion_index,
    input  logic [63:0]         data,
    output logic                tag_valid,
    output logic [TAG_BITS-1:0] tag,
    input  logic                tag_ready,
    output logic                out_valid,
    output logic [63:0]         out_data,
    input  logic                out_ready,
    output logic                err_unexpected
);
    localparam int NTAGS  = 1 << TAG_BITS;
    localparam int ADDR_W = TAG_BITS + IDX_W;
    localparam logic [TAG_BITS:0]   POOL_FULL = {1'b1, {TAG_BITS{1'b0}}};
    localparam logic [TAG_BITS:0]   PTR_ONE   = (TAG_BITS + 1)'(1);
    localparam logic [TAG_BITS-1:0] TAG_ONE   = TAG_BITS'(1);

    logic [TAG_BITS:0]  iss_q, iss_d;
    logic [TAG_BITS:0]  rel_q, rel_d;
    logic [CNT_W-1:0]   cnt_q [NTAGS];
    logic [CNT_W-1:0]   cnt_d [NTAGS];
    rd_state_e          state_q, state_d;
    logic [IDX_W-1:0]   ridx_q, ridx_d;
    logic               err_q, err_d;
    logic               rd_inflight_q, rd_inflight_d;
    logic [WORD_W-1:0]  fifo_mem_q [FIFO_DEPTH];
    logic [WORD_W-1:0]  fifo_mem_d [FIFO_DEPTH];
    logic               fifo_wptr_q, fifo_wptr_d;
    logic               fifo_rptr_q, fifo_rptr_d;
    logic [1:0]         fifo_cnt_q, fifo_cnt_d;

    logic [TAG_BITS:0]   in_flight;
    logic [TAG_BITS-1:0] rel_tag;
    logic [TAG_BITS-1:0] next_tag;
    logic [TAG_BITS-1:0] ctag;
    logic [TAG_BITS-1:0] tag_off;
    logic                cmp_ok;
    logic                wr_en;
    logic                rd_en;
    logic                last_rd;
    logic                next_ready;
    logic                pending;
    logic                pop;
    logic                space;
    logic [2:0]          occ;
    logic [ADDR_W-1:0]   wr_addr;
    logic [ADDR_W-1:0]   rd_addr;
    logic [WORD_W-1:0]   ram_rd_data;

    assign in_flight = iss_q - rel_q;
    assign rel_tag   = rel_q[TAG_BITS-1:0];
    assign next_tag  = rel_tag + TAG_ONE;
    assign pending   = (iss_q != rel_q);
    assign ctag      = completion_tag[TAG_BITS-1:0];
    assign tag_off   = ctag - rel_tag;

    // A tag is accepted only inside the window [rel, iss) and with no stray upper tag bits.
    assign cmp_ok  = ((completion_tag >> TAG_BITS) == 8'd0) && ({1'b0, tag_off} < in_flight);
    assign wr_en   = completion_valid && cmp_ok;
    assign wr_addr = {ctag, completion_index};
    assign rd_addr = {rel_tag, ridx_q};

    assign next_ready = ((rel_q + PTR_ONE) != iss_q) && (cnt_q[next_tag] == CNT_FULL);

    // Reads in flight count against FIFO space, so a stalled consumer never overflows it.
    assign pop   = (fifo_cnt_q != 2'd0) && out_ready;
    assign occ   = {1'b0, fifo_cnt_q} + {2'b00, rd_inflight_q};
    assign space = occ < (3'd2 + {2'b00, pop});

    always_comb begin
        state_d = state_q;
        ridx_d  = ridx_q;
        rel_d   = rel_q;
        rd_en   = 1'b0;
        last_rd = 1'b0;
        case (state_q)
            RD_IDLE: begin
                if (pending && (cnt_q[rel_tag] == CNT_FULL) && space) begin
                    rd_en   = 1'b1;
                    state_d = RD_STREAM;
                end
            end
            RD_STREAM: begin
                if (space) begin
                    rd_en = 1'b1;
                end
            end
            default: state_d = RD_IDLE;
        endcase
        if (rd_en) begin
            ridx_d = ridx_q + IDX_ONE;
            if (ridx_q == IDX_LAST) begin
                last_rd = 1'b1;
                rel_d   = rel_q + PTR_ONE;
                state_d = next_ready ? RD_STREAM : RD_IDLE;
            end
        end
    end

    always_comb begin
        iss_d = iss_q;
        if (tag_valid && tag_ready) begin
            iss_d = iss_q + PTR_ONE;
        end
        err_d = err_q | (completion_valid && !cmp_ok);
        cnt_d = cnt_q;
        if (wr_en) begin
            cnt_d[ctag] = cnt_q[ctag] + CNT_ONE;
        end
        if (last_rd) begin
            cnt_d[rel_tag] = '0;
        end
    end

    always_comb begin
        fifo_mem_d    = fifo_mem_q;
        fifo_wptr_d   = fifo_wptr_q;
        fifo_rptr_d   = fifo_rptr_q;
        rd_inflight_d = rd_en;
        if (rd_inflight_q) begin
            fifo_mem_d[fifo_wptr_q] = ram_rd_data;
            fifo_wptr_d             = ~fifo_wptr_q;
        end
        if (pop) begin
            fifo_rptr_d = ~fifo_rptr_q;
        end
        fifo_cnt_d = fifo_cnt_q + {1'b0, rd_inflight_q} - {1'b0, pop};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            iss_q         <= '0;
            rel_q         <= '0;
            cnt_q         <= '{default: '0};
            state_q       <= RD_IDLE;
            ridx_q        <= '0;
            err_q         <= 1'b0;
            rd_inflight_q <= 1'b0;
            fifo_wptr_q   <= 1'b0;
            fifo_rptr_q   <= 1'b0;
            fifo_cnt_q    <= 2'd0;
        end else begin
            iss_q         <= iss_d;
            rel_q         <= rel_d;
            cnt_q         <= cnt_d;
            state_q       <= state_d;
            ridx_q        <= ridx_d;
            err_q         <= err_d;
            rd_inflight_q <= rd_inflight_d;
            fifo_wptr_q   <= fifo_wptr_d;
            fifo_rptr_q   <= fifo_rptr_d;
            fifo_cnt_q    <= fifo_cnt_d;
        end
    end

    always_ff @(posedge clock) begin
        fifo_mem_q <= fifo_mem_d;
    end

    pcie_rx_reorder_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clock   (clock),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (data),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (ram_rd_data)
    );

    assign tag_valid      = (in_flight != POOL_FULL);
    assign tag            = iss_q[TAG_BITS-1:0];
    assign out_valid      = (fifo_cnt_q != 2'd0);
    assign out_data       = out_valid ? fifo_mem_q[fifo_rptr_q] : '0;
    assign err_unexpected = err_q;
endmodule

// File: tb/tb_pcie_rx_reorder.sv
// Scoreboard bench for pcie_rx_reorder: expected words are queued in tag-issue
// order when tags are issued and popped as the DUT hands words to the consumer.
module tb_pcie_rx_reorder;
    logic        clock = 1'b0;
    logic        reset;
    logic        completion_valid;
    logic [7:0]  completion_tag;
    logic [5:0]  completion_index;
    logic [63:0] data;
    logic        tag_valid;
    logic [4:0]  tag;
    logic        tag_ready;
    logic        out_valid;
    logic [63:0] out_data;
    logic        out_ready;
    logic        err_unexpected;

    int          n_cmp = 0;
    int          n_err = 0;
    int          n_rx  = 0;
    int          iss_m = 0;
    logic [63:0] exp_q [$];
    bit          rnd_ready   = 1'b0;
    bit          stall_armed = 1'b0;
    logic [63:0] stall_data;

    pcie_rx_reorder #(.TAG_BITS(5)) dut (
        .clock            (clock),
        .reset            (reset),
        .completion_valid (completion_valid),
        .completion_tag   (completion_tag),
        .completion_index (completion_index),
        .data             (data),
        .tag_valid        (tag_valid),
        .tag              (tag),
        .tag_ready        (tag_ready),
        .out_valid        (out_valid),
        .out_data         (out_data),
        .out_ready        (out_ready),
        .err_unexpected   (err_unexpected)
    );

    always #5 clock = ~clock;

    function automatic logic [63:0] mk(input int run, input int t, input int i);
        return {16'hBEEF, run[15:0], t[15:0], i[15:0]};
    endfunction

    // One clock: scoreboard the handshake at the negedge, then return just after the posedge.
    task automatic cycle();
        logic [63:0] exp_w;
        @(negedge clock);
        if (!reset) begin
            if (stall_armed) begin
                n_cmp++;
                if (out_valid !== 1'b1 || out_data !== stall_data) begin
                    n_err++;
                    $display("FAIL stall_hold: out_valid=%0b out_data=%h, required 1 / %h",
                             out_valid, out_data, stall_data);
                end
            end
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                n_cmp++;
                n_rx++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL spurious_word: got %h, required no output", out_data);
                end else begin
                    exp_w = exp_q.pop_front();
                    if (out_data !== exp_w) begin
                        n_err++;
                        $display("FAIL stream_word: got %h, required %h", out_data, exp_w);
                    end
                end
            end
            stall_armed = (out_valid === 1'b1) && (out_ready === 1'b0);
            stall_data  = out_data;
        end else begin
            stall_armed = 1'b0;
        end
        @(posedge clock);
        #1;
        if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic do_reset();
        reset            = 1'b1;
        completion_valid = 1'b0;
        tag_ready        = 1'b0;
        cycle();
        cycle();
        reset = 1'b0;
        exp_q.delete();
        iss_m = 0;
    endtask

    task automatic issue(input int n, input int run, input bit push);
        logic [4:0] et;
        for (int k = 0; k < n; k++) begin
            et = 5'(iss_m);
            n_cmp++;
            if (tag_valid !== 1'b1 || tag !== et) begin
                n_err++;
                $display("FAIL issue_tag: tag_valid=%0b tag=%0d, required 1 / %0d", tag_valid, tag, et);
            end
            if (push) begin
                for (int i = 0; i < 64; i++) exp_q.push_back(mk(run, iss_m % 32, i));
            end
            tag_ready = 1'b1;
            cycle();
            iss_m++;
        end
        tag_ready = 1'b0;
    endtask

    task automatic deliver(input int t, input int run);
        for (int i = 0; i < 64; i++) begin
            completion_valid = 1'b1;
            completion_tag   = 8'(t);
            completion_index = 6'(i);
            data             = mk(run, t, i);
            cycle();
        end
        completion_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        int k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            cycle();
            k++;
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain_timeout: %0d words outstanding, required 0", exp_q.size());
        end
        repeat (4) cycle();
    endtask

    task automatic test_reset();
        reset            = 1'b1;
        completion_valid = 1'b0;
        completion_tag   = 8'd0;
        completion_index = 6'd0;
        data             = 64'd0;
        tag_ready        = 1'b0;
        out_ready        = 1'b1;
        repeat (3) cycle();
        reset = 1'b0;
        cycle();
        n_cmp++;
        if (tag_valid !== 1'b1 || tag !== 5'd0) begin
            n_err++;
            $display("FAIL reset_tag: tag_valid=%0b tag=%0d, required 1 / 0", tag_valid, tag);
        end
        n_cmp++;
        if (out_valid !== 1'b0 || out_data !== 64'd0) begin
            n_err++;
            $display("FAIL reset_out: out_valid=%0b out_data=%h, required 0 / 0", out_valid, out_data);
        end
        n_cmp++;
        if (err_unexpected !== 1'b0) begin
            n_err++;
            $display("FAIL reset_err: err_unexpected=%0b, required 0", err_unexpected);
        end
    endtask

    task automatic test_out_of_order();
        int base = n_rx;
        issue(4, 1, 1'b1);
        deliver(3, 1);
        deliver(1, 1);
        deliver(0, 1);
        deliver(2, 1);
        drain(600);
        n_cmp++;
        if (n_rx - base !== 256) begin
            n_err++;
            $display("FAIL ooo_count: got %0d words, required 256", n_rx - base);
        end
    endtask

    task automatic test_latency();
        int gaps = 0;
        issue(1, 2, 1'b1);
        deliver(4, 2);
        // now just after edge E, which captured the final word
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL lat_e0: out_valid=%0b, required 0", out_valid);
        end
        cycle();
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL lat_e1: out_valid=%0b, required 0", out_valid);
        end
        cycle();
        n_cmp++;
        if (out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL lat_e2: out_valid=%0b, required 1", out_valid);
        end
        for (int k = 0; k < 64; k++) begin
            if (out_valid !== 1'b1) gaps++;
            cycle();
        end
        n_cmp++;
        if (gaps !== 0) begin
            n_err++;
            $display("FAIL lat_gapless: got %0d idle cycles, required 0", gaps);
        end
        drain(20);
    endtask

    task automatic test_random_ready();
        issue(2, 3, 1'b1);
        rnd_ready = 1'b1;
        deliver(5, 3);
        deliver(6, 3);
        drain(2000);
        rnd_ready = 1'b0;
        out_ready = 1'b1;
        cycle();
    endtask

    task automatic test_unexpected();
        int seen = 0;
        do_reset();
        issue(3, 0, 1'b0);
        n_cmp++;
        if (err_unexpected !== 1'b0) begin
            n_err++;
            $display("FAIL unexp_pre: err_unexpected=%0b, required 0", err_unexpected);
        end
        completion_valid = 1'b1;
        completion_tag   = 8'd7;
        completion_index = 6'd0;
        data             = mk(4, 7, 0);
        cycle();
        completion_valid = 1'b0;
        n_cmp++;
        if (err_unexpected !== 1'b1) begin
            n_err++;
            $display("FAIL unexp_flag: err_unexpected=%0b, required 1", err_unexpected);
        end
        n_cmp++;
        if (dut.cnt_q[7] !== 7'd0) begin
            n_err++;
            $display("FAIL unexp_cnt7: cnt[7]=%0d, required 0", dut.cnt_q[7]);
        end
        for (int k = 0; k < 8; k++) begin
            if (out_valid !== 1'b0) seen++;
            cycle();
        end
        n_cmp++;
        if (seen !== 0 || err_unexpected !== 1'b1) begin
            n_err++;
            $display("FAIL unexp_quiet: out_valid cycles=%0d err=%0b, required 0 / 1", seen, err_unexpected);
        end
    endtask

    task automatic test_mid_reset();
        int base;
        int k = 0;
        do_reset();
        out_ready = 1'b1;
        base = n_rx;
        issue(1, 5, 1'b1);
        deliver(0, 5);
        while (n_rx - base < 30 && k < 300) begin
            cycle();
            k++;
        end
        n_cmp++;
        if (n_rx - base !== 30) begin
            n_err++;
            $display("FAIL mid_count: got %0d words before reset, required 30", n_rx - base);
        end
        reset     = 1'b1;
        out_ready = 1'b0;
        cycle();
        n_cmp++;
        if (out_valid !== 1'b0 || tag_valid !== 1'b1 || tag !== 5'd0) begin
            n_err++;
            $display("FAIL mid_reset: out_valid=%0b tag_valid=%0b tag=%0d, required 0 / 1 / 0",
                     out_valid, tag_valid, tag);
        end
        reset = 1'b0;
        exp_q.delete();
        iss_m     = 0;
        out_ready = 1'b1;
        cycle();
        base = n_rx;
        issue(1, 6, 1'b1);
        deliver(0, 6);
        drain(300);
        n_cmp++;
        if (n_rx - base !== 64) begin
            n_err++;
            $display("FAIL mid_fresh: got %0d words, required 64", n_rx - base);
        end
    endtask

    task automatic test_pool_full();
        do_reset();
        out_ready = 1'b1;
        issue(1, 7, 1'b1);
        issue(31, 7, 1'b0);
        n_cmp++;
        if (tag_valid !== 1'b0) begin
            n_err++;
            $display("FAIL pool_full: tag_valid=%0b, required 0", tag_valid);
        end
        tag_ready = 1'b1;
        cycle();
        cycle();
        tag_ready = 1'b0;
        n_cmp++;
        if (tag_valid !== 1'b0 || tag !== 5'd0) begin
            n_err++;
            $display("FAIL pool_hold: tag_valid=%0b tag=%0d, required 0 / 0", tag_valid, tag);
        end
        deliver(0, 7);
        drain(300);
        n_cmp++;
        if (tag_valid !== 1'b1 || tag !== 5'd0) begin
            n_err++;
            $display("FAIL pool_wrap: tag_valid=%0b tag=%0d, required 1 / 0", tag_valid, tag);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_out_of_order();
        test_latency();
        test_random_ready();
        test_unexpected();
        test_mid_reset();
        test_pool_full();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
